// File: rtl/apb_bus_arbiter.sv
// Two-requester round-robin arbiter that sequences one shared APB3 slave port.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES cycles.
module apb_bus_arbiter #(
  parameter int AW             = 4,
  parameter int DW             = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          grant,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0] state;
  logic       last;
  logic       elig0;
  logic       elig1;
  logic       win;
  logic       timeout;

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    // A requester is masked in its own done cycle so a still-high req is not re-granted.
    elig0 = req0 & ~done0;
    elig1 = req1 & ~done1;
    win   = (elig0 & elig1) ? ~last : elig1;
  end

  assign PSEL    = (state != ST_IDLE);
  assign PENABLE = (state == ST_ACCESS);

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_cnt <= '0;
    end else if (state == ST_SETUP) begin
      wait_cnt <= '0;
    end else if (state == ST_ACCESS && !PREADY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Fires on the edge that would complete the TIMEOUT_CYCLES-th wait cycle.
  assign timeout = !PREADY && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      last      <= 1'b1;
      grant     <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (elig0 | elig1) begin
            grant  <= win;
            last   <= win;
            PADDR  <= win ? addr1  : addr0;
            PWRITE <= win ? we1    : we0;
            PWDATA <= win ? wdata1 : wdata0;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: state <= ST_ACCESS;
        ST_ACCESS: begin
          // A ready slave wins over a timeout that lands on the same cycle.
          if (PREADY || timeout) begin
            rsp_err <= PREADY ? PSLVERR : 1'b1;
            if (!PWRITE) begin
              rsp_rdata <= PREADY ? PRDATA : '0;
            end
            done0 <= ~grant;
            done1 <= grant;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
